// File: rtl/keypad_scan.sv
// keypad_scan: samples row lines against a one-hot column strobe, debounces complete frames and queues key events.
// Define KEYPAD_SCAN_RELEASE_EN to also report key releases, served after all pending presses.
module keypad_scan #(
    parameter int WIDTH    = 4,
    parameter int ROWS     = 4,
    parameter int DEBOUNCE = 4,
    localparam int KEYS    = WIDTH * ROWS,
    localparam int CODE_W  = (KEYS > 1) ? $clog2(KEYS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  col_sel,
    input  logic [ROWS-1:0]   row_in,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    output logic              key_release,
    input  logic              key_ready,
    output logic              frame_err
);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

    logic [KEYS-1:0]   snap, snap_w, frame, last_frame, stable_map, press_new, consumed, pend, pend_n;
    logic [WIDTH-1:0]  seen;
    logic [CNT_W-1:0]  stable_cnt, cnt_n;
    logic              onehot, fend, discard, complete, accept, valid_n;
    logic [CODE_W-1:0] code_n;

    function automatic logic [CODE_W-1:0] lsb_idx(input logic [KEYS-1:0] v);
        lsb_idx = '0;
        for (int i = KEYS - 1; i >= 0; i--)
            if (v[i]) lsb_idx = CODE_W'(i);
    endfunction

    // Column 0 is never stored: it always closes the frame and is merged straight from row_in.
    always_comb begin
        snap_w = snap;
        for (int c = 1; c < WIDTH; c++)
            if (col_sel[c]) snap_w[c*ROWS +: ROWS] = row_in;
        onehot    = (col_sel != '0) && ((col_sel & (col_sel - WIDTH'(1))) == '0);
        fend      = onehot && col_sel[0];
        discard   = !onehot || (seen & col_sel) != '0 || (fend && !(&(seen | col_sel)));
        complete  = fend && !discard;
        frame     = snap | KEYS'(row_in);
        cnt_n     = (frame != last_frame) ? CNT_W'(1) : (stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + CNT_W'(1);
        accept    = complete && cnt_n == CNT_MAX && frame != stable_map;
        press_new = accept ? frame & ~stable_map : '0;
    end

`ifdef KEYPAD_SCAN_RELEASE_EN
    logic [KEYS-1:0] rel_pend, rel_n, rel_consumed;

    always_comb begin
        consumed     = (key_valid && key_ready && !key_release) ? KEYS'(1) << key_code : '0;
        rel_consumed = (key_valid && key_ready && key_release) ? KEYS'(1) << key_code : '0;
        pend_n       = (pend & ~consumed) | press_new;
        rel_n        = (rel_pend & ~rel_consumed) | (accept ? stable_map & ~frame : '0);
        valid_n      = (pend_n != '0) || (rel_n != '0);
        code_n       = (pend_n != '0) ? lsb_idx(pend_n) : lsb_idx(rel_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rel_pend    <= '0;
            key_release <= 1'b0;
        end else begin
            rel_pend    <= rel_n;
            key_release <= (pend_n == '0) && (rel_n != '0);
        end
    end
`else
    always_comb begin
        consumed = (key_valid && key_ready) ? KEYS'(1) << key_code : '0;
        pend_n   = (pend & ~consumed) | press_new;
        valid_n  = pend_n != '0;
        code_n   = lsb_idx(pend_n);
    end

    assign key_release = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap       <= '0;
            seen       <= '0;
            last_frame <= '0;
            stable_map <= '0;
            stable_cnt <= '0;
            pend       <= '0;
            key_valid  <= 1'b0;
            key_code   <= '0;
            frame_err  <= 1'b0;
        end else begin
            frame_err  <= discard;
            snap       <= (discard || fend) ? '0 : snap_w;
            seen       <= (discard || fend) ? '0 : seen | col_sel;
            stable_cnt <= discard ? '0 : complete ? cnt_n : stable_cnt;
            if (complete) last_frame <= frame;
            if (accept) stable_map <= frame;
            pend       <= pend_n;
            key_valid  <= valid_n;
            key_code   <= code_n;
        end
    end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: drives a ring-counter column strobe with directed and random key patterns,
// checking every cycle against a frame-history model of the keypad scanner.
module tb_keypad_scan;
    localparam int DB = 4;
`ifdef KEYPAD_SCAN_RELEASE_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic       clk = 1'b0, rst_n = 1'b0, key_ready = 1'b0;
    logic [3:0] col_sel = '0, row_in = '0;
    logic       key_valid, key_release, frame_err;
    logic [3:0] key_code;

    int         n_chk = 0, n_fail = 0;
    bit [15:0]  pend_m, rel_m, stab_m, held;
    bit [3:0]   got;
    bit [3:0]   cap [4];
    bit [15:0]  hist [$];
    bit [15:0]  pool [4] = '{16'h0200, 16'h1008, 16'h0000, 16'h8421};

    keypad_scan #(.WIDTH(4), .ROWS(4), .DEBOUNCE(DB)) dut (
        .clk(clk), .rst_n(rst_n), .col_sel(col_sel), .row_in(row_in),
        .key_valid(key_valid), .key_code(key_code), .key_release(key_release),
        .key_ready(key_ready), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    function automatic int lowest(input bit [15:0] v);
        for (int i = 0; i < 16; i++)
            if (v[i]) return i;
        return 0;
    endfunction

    function automatic bit exp_valid();
        return pend_m != 0 || (REL && rel_m != 0);
    endfunction

    function automatic int exp_code();
        return pend_m != 0 ? lowest(pend_m) : lowest(rel_m);
    endfunction

    function automatic bit exp_rel();
        return REL && pend_m == 0 && rel_m != 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend_m = 0; rel_m = 0; stab_m = 0; got = 0;
        hist.delete();
    endtask

    // One clock: apply inputs, advance the model by the scanning rules, then check all outputs.
    task automatic cyc(input logic [3:0] cs, input logic [3:0] r, input bit rdy);
        bit err, eq;
        bit [15:0] f;
        int c;
        col_sel = cs; row_in = r; key_ready = rdy;
        if (rdy && exp_valid()) begin
            if (pend_m != 0) pend_m[lowest(pend_m)] = 1'b0;
            else rel_m[lowest(rel_m)] = 1'b0;
        end
        err = 1'b0;
        if ($countones(cs) != 1) err = 1'b1;
        else begin
            c = $clog2(cs);
            if (got[c]) err = 1'b1;
            else if (c != 0) begin
                got[c] = 1'b1;
                cap[c] = r;
            end else if (got[3:1] != 3'b111) err = 1'b1;
            else begin
                got = 0;
                f = {cap[3], cap[2], cap[1], r};
                hist.push_back(f);
                if (hist.size() > DB) void'(hist.pop_front());
                if (hist.size() == DB) begin
                    eq = 1'b1;
                    foreach (hist[i]) if (hist[i] != f) eq = 1'b0;
                    if (eq && f != stab_m) begin
                        pend_m |= f & ~stab_m;
                        rel_m  |= stab_m & ~f;
                        stab_m  = f;
                    end
                end
            end
        end
        if (err) begin
            got = 0;
            hist.delete();
        end
        @(posedge clk);
        #1;
        chk("frame_err", frame_err, err);
        chk("key_valid", key_valid, exp_valid());
        if (exp_valid()) chk("key_code", key_code, exp_code());
        chk("key_release", key_release, exp_rel());
    endtask

    // mode: 0 = ready low, 1 = ready high, 2 = random ready each cycle
    task automatic frame(input bit [15:0] keys, input int mode);
        for (int c = 3; c >= 0; c--)
            cyc(4'b0001 << c, keys[c*4 +: 4], mode == 2 ? bit'($urandom_range(0, 1)) : mode == 1);
    endtask

    task automatic hold(input bit [15:0] keys, input int n, input int mode);
        held = keys;
        repeat (n) frame(keys, mode);
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && exp_valid(); i++) frame(held, 1);
        chk("drained", key_valid, 1'b0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, key_valid, 1'b0);
        chk({tag, "_code"}, key_code, 4'd0);
        chk({tag, "_release"}, key_release, 1'b0);
        chk({tag, "_frame_err"}, frame_err, 1'b0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        // key 9 (col 2, row 1): reported after the 4th frame end, accepted in the 6th frame
        hold(16'h0200, 5, 0);
        hold(16'h0200, 1, 1);
        hold(16'h0000, 4, 0);
        drain();
        // key 9 only in alternate frames never settles
        for (int i = 0; i < 10; i++) frame((i % 2) ? 16'h0200 : 16'h0000, 1);
        hold(16'h0000, 4, 1);
        // keys 3 and 12 settle together, ready held high
        hold(16'h1008, 5, 1);
        hold(16'h0000, 5, 1);
        // multi-hot strobe mid-frame discards, then 4 clean frames are needed
        hold(16'h0200, 2, 0);
        cyc(4'b1000, 4'b0000, 1'b0);
        cyc(4'b0100, 4'b0010, 1'b0);
        cyc(4'b0110, 4'b0010, 1'b0);
        hold(16'h0200, 4, 0);
        // asynchronous reset mid-frame with key 9 pending
        cyc(4'b1000, 4'b0000, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_reset("async_reset");
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        hold(16'h0200, 5, 0);
        drain();
        // release of key 9: an event only when release tracking is built in
        hold(16'h0000, 5, 0);
        drain();
        // random patterns, random ready, occasional strobe glitches
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 15) == 0)
                cyc(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
            else begin
                if ($urandom_range(0, 5) == 0) held = pool[$urandom_range(0, 3)];
                frame(held, 2);
            end
        end
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
